alu_pipe_hs: RTL and testbench
==============================

Name: alu_pipe_hs

Overview:
- Parametrised, registered successor to the datapath's 32-bit combinational ALU.
- Generalises operand width and adds XOR/NOR, shifts, unsigned compare, an iterative multiply, and full N/Z/C/V flags.
- Uses a valid/ready handshake on input and output so the execute stage can stall around multi-cycle operations.
- Sits in the EX stage between the ID/EX register and the EX/MEM register.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts the request this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount.
- alu_control  in  4  opcode.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  ADD carry-out; SUB no-borrow (a >= b unsigned); 0 for all other ops.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- illegal  out  1  opcode not in the table below.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL.
  - 0110 SUB; 0111 SLT (signed); 1000 SLTU; 1001 SRA; 1010 MUL (low WIDTH bits of a*b); 1100 NOR.
  - Any other opcode: result 0, illegal=1, zero=1, other flags 0; still handshaken as a single-cycle op.
- Accept: a transfer occurs on the rising edge where in_valid && in_ready. Operands and opcode are captured at that edge; later input changes are ignored.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational, with no dependence on in_valid.
- Single-cycle ops: accepted at edge k; result and flags are written at edge k; out_valid=1 after edge k. A back-to-back stream sustains 1 op/cycle while out_ready=1.
- States:
  - IDLE: on accepting MUL, go to MUL_RUN. Load the multiplicand and multiplier shift registers, clear the accumulator, and set cnt=WIDTH. All other accepted ops stay in IDLE.
  - MUL_RUN: each cycle, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt -= 1. When cnt==1, write the final acc to result and set out_valid=1; the flags follow that value, with carry=overflow=0. Then return to IDLE.
  - MUL latency: out_valid rises WIDTH cycles after the accepting edge. in_ready=0 throughout MUL_RUN.
- Output hold: while out_valid && !out_ready, result, all flags and out_valid are stable. A new accept cannot overwrite them.
- Output release: out_valid && out_ready with no same-cycle accept or MUL completion clears out_valid at that edge. A same-cycle accept replaces the result and keeps out_valid=1.
- Widths:
  - ADD/SUB computed at WIDTH+1 bits; carry is bit WIDTH (for SUB, a + ~b + 1).
  - V = (a[MSB]==b'[MSB]) && (res[MSB]!=a[MSB]), where b' = b for ADD and ~b for SUB.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - SRA replicates a[MSB]. Shift amount uses only b[SHW-1:0]; upper bits of b are ignored.
- Reset (rst_n low, any time, including mid-MUL):
  - out_valid=0, result=0.
  - zero=1, negative=0, carry=0, overflow=0, illegal=0.
  - state=IDLE, cnt=0, MUL registers cleared.
  - in_ready=1 from the first clock after release.
- The block has no combinational path from a, b or alu_control to any output.

Test Plan:
- WIDTH=32, out_ready=1. ADD a=0x7FFFFFFF, b=0x00000001 -> after 1 edge: result=0x80000000, N=1, V=1, C=0, Z=0. Then SUB a=5, b=5 -> result=0, Z=1, C=1, V=0.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU with the same operands -> result=0. SRA a=0x80000000, b=0x0000003F -> 0xFFFFFFFF. SLL a=1, b=0x24 -> 0x00000010.
- MUL a=12345, b=678 -> in_ready=0 for 32 cycles. out_valid rises exactly 32 cycles after accept with result=8369910. MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0x00000001.
- Backpressure: out_ready=0, two ADDs presented back-to-back. The first result (3+4=7) is held stable and the second is not accepted. Raise out_ready for 1 cycle -> the second is accepted at the same edge and its result is valid next.
- Reset mid-operation: assert rst_n=0 at MUL cycle 10 -> out_valid=0, result=0, zero=1. After release, in_ready=1 and a new ADD 1+1 returns 2 in 1 cycle.
- Opcode 1111 with a=0xDEADBEEF -> result=0, illegal=1, Z=1, 1-cycle latency. The next legal op clears illegal.

Source files
------------

// File: rtl/alu_pipe_hs.sv
// Registered EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete at the accepting edge; MUL iterates shift-and-add over WIDTH cycles.
module alu_pipe_hs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             illegal
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic {IDLE, MUL_RUN} state_t;

   state_t           state;
   logic [SHW:0]     cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   logic             accept;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] op_res;
   logic             op_c;
   logic             op_v;
   logic             op_ill;
   logic [WIDTH-1:0] wr_res;
   logic             wr_c;
   logic             wr_v;
   logic             wr_ill;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = b[SHW-1:0];
   assign acc_step = acc + (mplier[0] ? mcand : '0);

   // SUB reuses the adder as a + ~b + 1 so carry means "no borrow".
   always_comb begin
      is_sub = (alu_control == OP_SUB);
      b_eff  = is_sub ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      op_ill = 1'b0;
      case (alu_control)
         OP_AND:  op_res = a & b;
         OP_OR:   op_res = a | b;
         OP_XOR:  op_res = a ^ b;
         OP_NOR:  op_res = ~(a | b);
         OP_SLL:  op_res = a << shamt;
         OP_SRL:  op_res = a >> shamt;
         OP_SRA:  op_res = $signed(a) >>> shamt;
         OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: op_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_ADD, OP_SUB: begin
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL:  op_res = '0;
         default: op_ill = 1'b1;
      endcase
   end

   always_comb begin
      wr_res = op_res;
      wr_c   = op_c;
      wr_v   = op_v;
      wr_ill = op_ill;
      if (state == MUL_RUN) begin
         wr_res = acc_step;
         wr_c   = 1'b0;
         wr_v   = 1'b0;
         wr_ill = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && alu_control == OP_MUL) begin
                  state     <= MUL_RUN;
                  mcand     <= a;
                  mplier    <= b;
                  acc       <= '0;
                  cnt       <= (SHW+1)'(WIDTH);
                  out_valid <= 1'b0;
               end else if (accept) begin
                  out_valid <= 1'b1;
                  result    <= wr_res;
                  zero      <= (wr_res == '0);
                  negative  <= wr_res[WIDTH-1];
                  carry     <= wr_c;
                  overflow  <= wr_v;
                  illegal   <= wr_ill;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            MUL_RUN: begin
               acc    <= acc_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == (SHW+1)'(1)) begin
                  state     <= IDLE;
                  out_valid <= 1'b1;
                  result    <= wr_res;
                  zero      <= (wr_res == '0);
                  negative  <= wr_res[WIDTH-1];
                  carry     <= wr_c;
                  overflow  <= wr_v;
                  illegal   <= wr_ill;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_pipe_hs.sv
// Scoreboard bench for alu_pipe_hs: expected results are queued at accept and compared at output handshake.
// Inputs change at posedge+1, in_ready is polled at posedge+4, outputs are consumed at negedge.
module tb_alu_pipe_hs;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_control;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero, negative, carry, overflow, illegal;

   int checks   = 0;
   int failures = 0;
   logic [36:0] exp_q[$];

   alu_pipe_hs #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Packed as {illegal, overflow, carry, negative, zero, result}.
   function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [32:0] s;
      logic [63:0] p;
      logic [31:0] r;
      logic c, v, ill;
      r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
      case (op)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h2: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[31:0];
            c = s[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
         end
         4'h3: r = x ^ y;
         4'h4: r = x << y[4:0];
         4'h5: r = x >> y[4:0];
         4'h6: begin
            r = x - y;
            c = (x >= y);
            v = (x[31] != y[31]) && (r[31] != x[31]);
         end
         4'h7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'h8: r = (x < y) ? 32'd1 : 32'd0;
         4'h9: begin
            r = x;
            for (int i = 0; i < int'(y[4:0]); i++) r = {r[31], r[31:1]};
         end
         4'hA: begin
            p = {32'b0, x} * {32'b0, y};
            r = p[31:0];
         end
         4'hC: r = ~(x | y);
         default: ill = 1'b1;
      endcase
      return {ill, v, c, r[31], (r == 32'd0), r};
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      int n;
      in_valid = 1'b1; alu_control = op; a = x; b = y;
      #3;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #4;
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", {63'b0, in_ready}, 64'd1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(model(op, x, y));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [36:0] e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", {63'b0, out_valid}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", {27'b0, illegal, overflow, carry, negative, zero, result}, {27'b0, e});
            $display("txn result=0x%08h ill=%0b v=%0b c=%0b n=%0b z=%0b", result, illegal, overflow, carry, negative, zero);
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [3:0] ops [12];
      int cycles, bad;
      ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC};
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {25'b0, out_valid, illegal, overflow, carry, negative, zero, result},
            {25'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);

      // Directed single-cycle ops
      send(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
      send(4'h6, 32'd5, 32'd5);
      send(4'h7, 32'hFFFF_FFFF, 32'd1);
      send(4'h8, 32'hFFFF_FFFF, 32'd1);
      send(4'h9, 32'h8000_0000, 32'h0000_003F);
      send(4'h4, 32'd1, 32'h0000_0024);
      drain();

      // MUL latency and in_ready stall
      send(4'hA, 32'd12345, 32'd678);
      cycles = 0; bad = 0;
      while (!out_valid && cycles < 100) begin
         if (in_ready) bad++;
         @(posedge clk); #1;
         cycles++;
      end
      check("mul_latency", 64'(cycles), 64'd32);
      check("mul_in_ready_low", 64'(bad), 64'd0);
      check("mul_value", {32'b0, result}, 64'd8369910);
      send(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drain();

      // Backpressure: first result held, second only accepted when out_ready rises
      out_ready = 1'b0;
      send(4'h2, 32'd3, 32'd4);
      fork
         send(4'h2, 32'd10, 32'd20);
         begin
            repeat (3) begin
               check("bp_hold", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'd7});
               check("bp_in_ready", {63'b0, in_ready}, 64'd0);
               @(posedge clk); #1;
            end
            #1 out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp_second", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'd30});
            @(posedge clk); #1;
            check("bp_second_hold", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'd30});
         end
      join
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a MUL
      send(4'hA, 32'd1000, 32'd1000);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_mul", {29'b0, out_valid, zero, result}, {29'b0, 1'b0, 1'b1, 32'd0});
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_ready", {63'b0, in_ready}, 64'd1);
      send(4'h2, 32'd1, 32'd1);
      check("post_rst_add", {31'b0, out_valid, result}, {31'b0, 1'b1, 32'd2});
      drain();

      // Illegal opcode, then a legal one clears the flag
      send(4'hF, 32'hDEAD_BEEF, 32'd0);
      check("illegal_1cyc", {30'b0, out_valid, illegal, result}, {30'b0, 1'b1, 1'b1, 32'd0});
      send(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      check("illegal_clear", {63'b0, illegal}, 64'd0);
      drain();

      // Random back-to-back stream
      for (int i = 0; i < 30; i++) begin
         send(ops[$urandom_range(0, 11)], $urandom, $urandom);
      end
      send(4'hB, $urandom, $urandom);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
